amm_arb2_rv: RTL and testbench

- Two-port Avalon MM arbiter with readdatavalid support.
- Shares one downstream Avalon MM master port between two upstream requesters. The downstream port typically feeds the Avalon-to-AHB-Lite single-cycle bridge.
- Arbitration is round-robin with the grant held while a command stalls.
- Read ownership is tracked in an in-order ID FIFO, so pipelined read data returns to the correct requester.

---
 rtl/amm_arb2_rv_if.sv | 25 ++
 rtl/amm_arb2_rv.sv | 184 ++++++++++++++++++
 tb/tb_amm_arb2_rv.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/amm_arb2_rv_if.sv
// amm_arb2_rv_if - one Avalon-MM link: command channel plus pipelined read
// response.
//   master modport : drives address/writedata/byteenable/write/read,
//                    receives readdata/readdatavalid/waitrequest
//   slave modport  : the mirror image (receives the command, answers it)
interface amm_arb2_rv_if;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        write;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output address, writedata, byteenable, write, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, writedata, byteenable, write, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/amm_arb2_rv.sv
// amm_arb2_rv - two-port Avalon-MM arbiter with readdatavalid routing.
// Shares one downstream master port between two upstream requesters using
// round-robin arbitration. The grant is held while a command is stalled by
// the downstream waitrequest. Read ownership is remembered in an in-order ID
// FIFO so pipelined read data returns to the requester that issued the read.
// The arbiter adds no latency to commands or to read data.
// Ports:
//   aclk, aresetn  : clock (rising edge), asynchronous active-low reset
//   s0, s1         : upstream requesters (slave side of the link)
//   m              : downstream port (master side of the link)
//   err_unexp_rdv  : sticky; readdatavalid arrived with no read outstanding
module amm_arb2_rv #(
    parameter int MAX_PEND = 4,
    parameter int PEND_W   = 2
) (
    input  logic          aclk,
    input  logic          aresetn,
    amm_arb2_rv_if.slave  s0,
    amm_arb2_rv_if.slave  s1,
    amm_arb2_rv_if.master m,
    output logic          err_unexp_rdv
);

    localparam logic [PEND_W:0] PEND_MAX = (PEND_W+1)'(MAX_PEND);

    logic                last_gnt_r;
    logic                hold_r;
    logic                hold_id_r;
    logic                err_r;
    logic [MAX_PEND-1:0] id_fifo_r;
    logic [PEND_W-1:0]   wr_ptr_r;
    logic [PEND_W-1:0]   rd_ptr_r;
    logic [PEND_W:0]     count_r;

    logic req0_s;
    logic req1_s;
    logic gnt_valid_s;
    logic gnt_id_s;
    logic pend_full_s;
    logic pend_empty_s;
    logic sel_read_s;
    logic sel_write_s;
    logic m_read_s;
    logic m_write_s;
    logic accept_s;
    logic stall_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    assign req0_s       = s0.read | s0.write;
    assign req1_s       = s1.read | s1.write;
    assign pend_full_s  = (count_r == PEND_MAX);
    assign pend_empty_s = (count_r == {(PEND_W+1){1'b0}});

    // Grant selection: a stalled command keeps its grant, otherwise a tie goes
    // to the port that did not win last time.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_id_s    = 1'b0;
        if (hold_r) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = hold_id_r;
        end else if (req0_s && !req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b0;
        end else if (!req0_s && req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = 1'b1;
        end else if (req0_s && req1_s) begin
            gnt_valid_s = 1'b1;
            gnt_id_s    = ~last_gnt_r;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_id_s    = 1'b0;
        end
    end

    // Command mux: port 0 drives the bus whenever port 1 is not granted.
    always_comb begin
        m.address    = s0.address;
        m.writedata  = s0.writedata;
        m.byteenable = s0.byteenable;
        sel_read_s   = s0.read;
        sel_write_s  = s0.write;
        if (gnt_valid_s && gnt_id_s) begin
            m.address    = s1.address;
            m.writedata  = s1.writedata;
            m.byteenable = s1.byteenable;
            sel_read_s   = s1.read;
            sel_write_s  = s1.write;
        end else begin
            m.address    = s0.address;
            m.writedata  = s0.writedata;
            m.byteenable = s0.byteenable;
            sel_read_s   = s0.read;
            sel_write_s  = s0.write;
        end
    end

    // Reads are withheld while the ID FIFO is full; writes are not tracked.
    assign m_write_s = gnt_valid_s & sel_write_s;
    assign m_read_s  = gnt_valid_s & sel_read_s & ~pend_full_s;
    assign m.write   = m_write_s;
    assign m.read    = m_read_s;

    // Per-port stall: non-granted ports always wait; the granted port waits on
    // the downstream stall or on a read blocked by a full ID FIFO.
    always_comb begin
        s0.waitrequest = 1'b1;
        s1.waitrequest = 1'b1;
        if (gnt_valid_s && !gnt_id_s) begin
            s0.waitrequest = m.waitrequest | (s0.read & pend_full_s);
        end else if (gnt_valid_s && gnt_id_s) begin
            s1.waitrequest = m.waitrequest | (s1.read & pend_full_s);
        end else begin
            s0.waitrequest = 1'b1;
            s1.waitrequest = 1'b1;
        end
    end

    assign accept_s = (m_read_s | m_write_s) & ~m.waitrequest;
    // A read blocked only by a full FIFO never reaches the bus, so it does not
    // lock the grant and can be overtaken by the other port.
    assign stall_s  = (m_read_s | m_write_s) & m.waitrequest;
    assign push_s   = m_read_s & ~m.waitrequest;
    assign pop_s    = m.readdatavalid & ~pend_empty_s;
    assign head_s   = id_fifo_r[rd_ptr_r];

    // Read data fans out to both ports; only the owner of the oldest read sees valid.
    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign s0.readdatavalid = pop_s & ~head_s;
    assign s1.readdatavalid = pop_s & head_s;
    assign err_unexp_rdv    = err_r;

    // Round-robin history and grant hold across downstream stalls.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_gnt_r <= 1'b1;
            hold_r     <= 1'b0;
            hold_id_r  <= 1'b0;
        end else if (accept_s) begin
            last_gnt_r <= gnt_id_s;
            hold_r     <= 1'b0;
        end else if (stall_s) begin
            hold_r     <= 1'b1;
            hold_id_r  <= gnt_id_s;
        end
    end

    // In-order read-owner FIFO; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            id_fifo_r <= {MAX_PEND{1'b0}};
            wr_ptr_r  <= {PEND_W{1'b0}};
            rd_ptr_r  <= {PEND_W{1'b0}};
            count_r   <= {(PEND_W+1){1'b0}};
        end else begin
            if (push_s) begin
                id_fifo_r[wr_ptr_r] <= gnt_id_s;
                wr_ptr_r            <= wr_ptr_r + PEND_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PEND_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PEND_W+1)'(1);
                2'b01:   count_r <= count_r - (PEND_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for read data that nobody asked for; cleared only by reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_r <= 1'b0;
        end else if (m.readdatavalid && pend_empty_s) begin
            err_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_amm_arb2_rv.sv
// tb_amm_arb2_rv - self-checking bench for amm_arb2_rv.
// A behavioural model (owner lock, last winner, queue of read owners, error
// flag) predicts every output on each falling edge; directed sequences with
// literal expectations pin the model, then randomized traffic follows.
`timescale 1ns/1ps
module tb_amm_arb2_rv;
    localparam int MAX_PEND = 4;

    logic aclk = 1'b0;
    logic aresetn;
    logic err_unexp_rdv;

    amm_arb2_rv_if s0_if ();
    amm_arb2_rv_if s1_if ();
    amm_arb2_rv_if m_if ();

    amm_arb2_rv #(.MAX_PEND(MAX_PEND), .PEND_W(2)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s0            (s0_if),
        .s1            (s1_if),
        .m             (m_if),
        .err_unexp_rdv (err_unexp_rdv)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int lock_m = -1;   // port whose stalled command owns the bus, -1 if none
    int last_m = 1;    // port that last completed a command
    int pend_m[$];     // owners of outstanding reads, oldest first
    bit err_m  = 1'b0;

    function automatic int mdl_owner();
        bit r0;
        bit r1;
        r0 = s0_if.read | s0_if.write;
        r1 = s1_if.read | s1_if.write;
        if (lock_m >= 0) return lock_m;
        if (r0 && r1) return 1 - last_m;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    function automatic bit own_read(input int own);
        if (own == 1) return s1_if.read;
        return s0_if.read;
    endfunction

    function automatic bit own_write(input int own);
        if (own == 1) return s1_if.write;
        return s0_if.write;
    endfunction

    task automatic mdl_step();
        int own;
        bit full;
        bit rd;
        bit wr;
        own  = mdl_owner();
        full = (pend_m.size() == MAX_PEND);
        rd   = (own >= 0) && own_read(own) && !full;
        wr   = (own >= 0) && own_write(own);
        if (m_if.readdatavalid) begin
            if (pend_m.size() > 0) void'(pend_m.pop_front());
            else err_m = 1'b1;
        end
        if (rd || wr) begin
            if (!m_if.waitrequest) begin
                last_m = own;
                lock_m = -1;
                if (rd) pend_m.push_back(own);
            end else begin
                lock_m = own;
            end
        end
    endtask

    // Model state follows the clock and the asynchronous reset.
    initial begin
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                lock_m = -1;
                last_m = 1;
                pend_m.delete();
                err_m  = 1'b0;
            end else begin
                mdl_step();
            end
        end
    end

    task automatic cmp_cycle();
        int own;
        bit full;
        bit w0;
        bit w1;
        bit v0;
        bit v1;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  eb;
        own  = mdl_owner();
        full = (pend_m.size() == MAX_PEND);
        ea = (own == 1) ? s1_if.address    : s0_if.address;
        ed = (own == 1) ? s1_if.writedata  : s0_if.writedata;
        eb = (own == 1) ? s1_if.byteenable : s0_if.byteenable;
        w0 = (own == 0) ? (m_if.waitrequest | (s0_if.read & full)) : 1'b1;
        w1 = (own == 1) ? (m_if.waitrequest | (s1_if.read & full)) : 1'b1;
        v0 = m_if.readdatavalid && (pend_m.size() > 0) && (pend_m[0] == 0);
        v1 = m_if.readdatavalid && (pend_m.size() > 0) && (pend_m[0] == 1);
        chk("m_address",    m_if.address,        ea);
        chk("m_writedata",  m_if.writedata,      ed);
        chk("m_byteenable", {28'd0, m_if.byteenable}, {28'd0, eb});
        chk("m_write",      {31'd0, m_if.write}, {31'd0, (own >= 0) && own_write(own)});
        chk("m_read",       {31'd0, m_if.read},  {31'd0, (own >= 0) && own_read(own) && !full});
        chk("s0_wait",      {31'd0, s0_if.waitrequest},   {31'd0, w0});
        chk("s1_wait",      {31'd0, s1_if.waitrequest},   {31'd0, w1});
        chk("s0_rdv",       {31'd0, s0_if.readdatavalid}, {31'd0, v0});
        chk("s1_rdv",       {31'd0, s1_if.readdatavalid}, {31'd0, v1});
        chk("s0_rdata",     s0_if.readdata, m_if.readdata);
        chk("s1_rdata",     s1_if.readdata, m_if.readdata);
        chk("err_flag",     {31'd0, err_unexp_rdv}, {31'd0, err_m});
    endtask

    // Every falling edge the DUT outputs are compared against the model.
    initial begin
        forever begin
            @(negedge aclk);
            cmp_cycle();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        s0_if.address = 32'd0; s0_if.writedata = 32'd0; s0_if.byteenable = 4'd0;
        s0_if.read = 1'b0; s0_if.write = 1'b0;
        s1_if.address = 32'd0; s1_if.writedata = 32'd0; s1_if.byteenable = 4'd0;
        s1_if.read = 1'b0; s1_if.write = 1'b0;
        m_if.readdata = 32'd0; m_if.readdatavalid = 1'b0; m_if.waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        idle();
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        idle();
        #2;
        // reset state
        chk("rst_s0_wait", {31'd0, s0_if.waitrequest}, 32'd1);
        chk("rst_s1_wait", {31'd0, s1_if.waitrequest}, 32'd1);
        chk("rst_m_cmd",   {30'd0, m_if.write, m_if.read}, 32'd0);
        chk("rst_err",     {31'd0, err_unexp_rdv}, 32'd0);
        tick();
        tick();
        aresetn = 1'b1;

        // single port write
        s0_if.write = 1'b1; s0_if.address = 32'h10; s0_if.writedata = 32'hA5A5A5A5;
        s0_if.byteenable = 4'hF;
        #2;
        chk("wr_m_write", {31'd0, m_if.write}, 32'd1);
        chk("wr_m_addr",  m_if.address, 32'h10);
        chk("wr_m_data",  m_if.writedata, 32'hA5A5A5A5);
        chk("wr_s0_wait", {31'd0, s0_if.waitrequest}, 32'd0);
        chk("wr_s1_wait", {31'd0, s1_if.waitrequest}, 32'd1);
        tick();
        idle();

        // alternating reads out of reset, data returned in issue order
        do_reset();
        s0_if.read = 1'b1; s0_if.address = 32'h100;
        s1_if.read = 1'b1; s1_if.address = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("alt_addr",    m_if.address, (i % 2 == 0) ? 32'h100 : 32'h200);
            chk("alt_s0_wait", {31'd0, s0_if.waitrequest}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        s0_if.read = 1'b0; s1_if.read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_if.readdatavalid = 1'b1; m_if.readdata = 32'(i + 1);
            #2;
            chk("alt_s0_rdv", {31'd0, s0_if.readdatavalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("alt_s1_rdv", {31'd0, s1_if.readdatavalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("alt_rdata",  s0_if.readdata, 32'(i + 1));
            tick();
        end
        idle();

        // grant held through a downstream stall
        do_reset();
        s0_if.write = 1'b1; s0_if.address = 32'h300;
        s1_if.write = 1'b1; s1_if.address = 32'h400;
        m_if.waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_addr",    m_if.address, 32'h300);
            chk("hold_s1_wait", {31'd0, s1_if.waitrequest}, 32'd1);
            tick();
        end
        m_if.waitrequest = 1'b0;
        #2;
        chk("hold_acc_addr", m_if.address, 32'h300);
        chk("hold_s0_wait",  {31'd0, s0_if.waitrequest}, 32'd0);
        tick();
        s0_if.write = 1'b0;
        #2;
        chk("hold_next_addr", m_if.address, 32'h400);
        chk("hold_next_wait", {31'd0, s1_if.waitrequest}, 32'd0);
        tick();
        idle();

        // FIFO full blocks reads, writes still pass
        do_reset();
        s0_if.read = 1'b1; s0_if.address = 32'h500;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("full_fill_rd", {31'd0, m_if.read}, 32'd1);
            tick();
        end
        s1_if.write = 1'b1; s1_if.address = 32'h600;
        #2;
        chk("full_m_read",  {31'd0, m_if.read}, 32'd0);
        chk("full_s0_wait", {31'd0, s0_if.waitrequest}, 32'd1);
        chk("full_wr_pass", {31'd0, m_if.write}, 32'd1);
        chk("full_wr_addr", m_if.address, 32'h600);
        tick();
        s1_if.write = 1'b0;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h55;
        #2;
        chk("full_still",  {31'd0, m_if.read}, 32'd0);
        chk("full_rdv_s0", {31'd0, s0_if.readdatavalid}, 32'd1);
        tick();
        m_if.readdatavalid = 1'b0;
        #2;
        chk("full_5th_rd",   {31'd0, m_if.read}, 32'd1);
        chk("full_5th_wait", {31'd0, s0_if.waitrequest}, 32'd0);
        tick();
        s0_if.read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_if.readdatavalid = 1'b1;
            #2;
            chk("full_drain", {31'd0, s0_if.readdatavalid}, 32'd1);
            tick();
        end
        idle();

        // push and pop in the same cycle, then unexpected read data
        do_reset();
        s0_if.read = 1'b1; s0_if.address = 32'h700;
        tick();
        tick();
        s0_if.read = 1'b0;
        s1_if.read = 1'b1; s1_if.address = 32'h780;
        m_if.readdatavalid = 1'b1; m_if.readdata = 32'h77;
        #2;
        chk("pp_m_read", {31'd0, m_if.read}, 32'd1);
        chk("pp_addr",   m_if.address, 32'h780);
        chk("pp_s0_rdv", {31'd0, s0_if.readdatavalid}, 32'd1);
        chk("pp_s1_rdv", {31'd0, s1_if.readdatavalid}, 32'd0);
        tick();
        s1_if.read = 1'b0;
        #2;
        chk("pp_2nd_s0", {31'd0, s0_if.readdatavalid}, 32'd1);
        tick();
        #2;
        chk("pp_3rd_s1", {31'd0, s1_if.readdatavalid}, 32'd1);
        chk("pp_3rd_s0", {31'd0, s0_if.readdatavalid}, 32'd0);
        tick();
        #2;
        chk("unexp_rdv", {30'd0, s1_if.readdatavalid, s0_if.readdatavalid}, 32'd0);
        chk("unexp_pre", {31'd0, err_unexp_rdv}, 32'd0);
        tick();
        m_if.readdatavalid = 1'b0;
        #2;
        chk("unexp_err", {31'd0, err_unexp_rdv}, 32'd1);
        tick();

        // reset in the middle of a read burst
        s0_if.read = 1'b1; s0_if.address = 32'h800;
        tick();
        tick();
        tick();
        s0_if.read = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("mrst_err",  {31'd0, err_unexp_rdv}, 32'd0);
        chk("mrst_wait", {31'd0, s0_if.waitrequest}, 32'd1);
        tick();
        aresetn = 1'b1;
        s0_if.write = 1'b1; s0_if.address = 32'h880;
        s1_if.write = 1'b1; s1_if.address = 32'h900;
        #2;
        chk("mrst_tie_addr", m_if.address, 32'h880);
        chk("mrst_tie_wait", {31'd0, s0_if.waitrequest}, 32'd0);
        tick();
        idle();
        m_if.readdatavalid = 1'b1;
        #2;
        chk("late_rdv", {30'd0, s1_if.readdatavalid, s0_if.readdatavalid}, 32'd0);
        tick();
        m_if.readdatavalid = 1'b0;
        #2;
        chk("late_err", {31'd0, err_unexp_rdv}, 32'd1);
        tick();

        // randomized traffic, checked by the model on every cycle
        for (int c = 0; c < 3000; c++) begin
            int k0;
            int k1;
            k0 = int'($urandom_range(0, 3));
            k1 = int'($urandom_range(0, 3));
            s0_if.read  = (k0 == 1); s0_if.write = (k0 == 2);
            s1_if.read  = (k1 == 1); s1_if.write = (k1 == 2);
            s0_if.address = $urandom(); s0_if.writedata = $urandom();
            s0_if.byteenable = 4'($urandom_range(0, 15));
            s1_if.address = $urandom(); s1_if.writedata = $urandom();
            s1_if.byteenable = 4'($urandom_range(0, 15));
            m_if.waitrequest = ($urandom_range(0, 3) == 0);
            m_if.readdata    = $urandom();
            if (pend_m.size() > 0) m_if.readdatavalid = ($urandom_range(0, 2) != 0);
            else m_if.readdatavalid = ($urandom_range(0, 40) == 0);
            aresetn = ($urandom_range(0, 499) != 0);
            tick();
        end
        aresetn = 1'b1;
        idle();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
